instr_mem_arbiter: RTL and testbench
====================================

Name: instr_mem_arbiter

Overview:
- Round-robin arbiter that shares one instruction-memory port among NUM_REQ fetchers (one per warp).
- Each requester side uses the fetcher's own protocol: `mem_valid` and `mem_addr` held until a one-cycle `mem_resp_ready` pulse. The memory side uses the same protocol.
- Sits between the per-warp fetchers and the instruction memory / cache.
- Exactly one memory transaction is in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesting fetchers; legal range 1..16.
- REQ_IDX_W, $clog2(NUM_REQ) (minimum 1), derived; width of grant index and round-robin pointer.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester fetch request, level; held until that requester's req_resp_ready pulse.
- req_addr  in  NUM_REQ x instr_mem_addr_t  per-requester fetch address; stable while req_valid is high.
- req_resp_ready  out  NUM_REQ  one-cycle response pulse per requester.
- req_resp_data  out  instr_t  shared response data bus; valid in any cycle where some req_resp_ready bit is 1.
- mem_valid  out  1  memory request, held until mem_resp_ready.
- mem_addr  out  instr_mem_addr_t  memory address.
- mem_resp_ready  in  1  memory response strobe; honoured only in ARB_ISSUE.
- mem_resp_data  in  instr_t  memory response data.

Behaviour:
- Reset (reset=1 at a clk edge) forces:
  - state=ARB_IDLE, rr_ptr=0, grant=0
  - mem_valid=0, mem_addr=0
  - req_resp_ready=0, req_resp_data=0
- Reset mid-transaction abandons the transaction; a late mem_resp_ready is ignored because the state is ARB_IDLE.
- ARB_IDLE:
  - If any req_valid bit is set, pick g = first set bit, searching upward from rr_ptr with wrap.
  - Register grant<=g, mem_addr<=req_addr[g], mem_valid<=1, state<=ARB_ISSUE.
  - If no bit is set, hold.
- ARB_ISSUE:
  - mem_valid stays high and mem_addr stays stable.
  - On mem_resp_ready=1: mem_valid<=0, req_resp_data<=mem_resp_data, req_resp_ready[grant]<=1, rr_ptr<=(grant+1) mod NUM_REQ, state<=ARB_RESP.
- ARB_RESP:
  - req_resp_ready is high for exactly this cycle; the fetcher drops its req_valid at the closing edge.
  - Clear req_resp_ready, state<=ARB_IDLE.
  - req_resp_data holds its value until the next response.
- Latency: req_valid sampled in cycle c gives mem_valid high in c+1. With a memory responding in c+1, req_resp_ready is high in c+2. Minimum 2 cycles plus memory latency.
- Issue rate: one transaction per 3 cycles minimum (IDLE, ISSUE, RESP).
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 other grants.
- Requester-side boundary cases:
  - Requests arriving while the arbiter is busy wait; they are not queued beyond their own held req_valid.
  - req_valid dropped by the granted requester mid-ISSUE is a protocol violation; the transaction still completes and the pulse is still issued.
- Memory-side and degenerate cases:
  - mem_resp_ready in IDLE or RESP is ignored.
  - NUM_REQ=1: rr_ptr is constant 0; behaviour is otherwise identical.
- State encoding other than the three states: $error, then go to ARB_IDLE.

Optional Feature:
- Macro: ARB_ADDR_BROADCAST_EN.
- Enabled: at the ISSUE→RESP edge, set req_resp_ready[i] for the granted requester plus every i with req_valid[i]=1 and req_addr[i]==mem_addr. Warps fetching the same PC are served by one memory access. rr_ptr still advances to grant+1.
- Disabled: only req_resp_ready[grant] is ever set.

Decomposition:
- common_pkg gains:
  - arb_state_t enum {ARB_IDLE, ARB_ISSUE, ARB_RESP}
  - constant INSTR_ARB_NUM_REQ (default requester count)
- instr_mem_addr_t and instr_t are reused from common_pkg unchanged.
- One sub-module: rr_priority_picker. Combinational; inputs are the request vector and rr_ptr; outputs are any_req and grant index; parameterised by NUM_REQ. It is reusable for a future data-memory arbiter.

Test Plan:
- Single request: reset, req_valid=4'b0001, req_addr[0]=0x10, memory responds 1 cycle after mem_valid with 0xDEADBEEF → mem_addr=0x10; req_resp_ready=4'b0001 for exactly 1 cycle, 2 cycles after req_valid; req_resp_data=0xDEADBEEF.
- Round-robin: all four req_valid held high, each cleared after its own pulse → grant order 0,1,2,3. With rr_ptr=2 and requests {0,3} → grant 3, then 0.
- Memory stall: memory withholds mem_resp_ready for 5 cycles → mem_valid and mem_addr stable throughout; no req_resp_ready; no second grant.
- Reset mid-ISSUE: reset during ISSUE, then mem_resp_ready=1 arrives → all outputs 0, no pulse, next grant starts from requester 0.
- Spurious strobe: mem_resp_ready=1 while IDLE with no requests → no output change.
- Broadcast (macro defined): req 1 and req 3 both valid with addr 0x40, rr_ptr=1 → one memory access; req_resp_ready=4'b1010 in the same cycle; rr_ptr becomes 2. With the macro undefined → two separate accesses.

Source files
------------

// File: rtl/common_pkg.sv
// Shared fetch-path types and the instruction-memory arbiter state encoding.
// Compile-time option for the arbiter: ARB_ADDR_BROADCAST_EN.
package common_pkg;

  typedef logic [31:0] instr_mem_addr_t;
  typedef logic [31:0] instr_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_t;

  localparam int INSTR_ARB_NUM_REQ = 4;

  // Index width for n requesters; a single requester still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above rr_ptr, with wrap.
// Shared by the instruction-memory arbiter and intended for a data-memory arbiter.
module rr_priority_picker
  import common_pkg::*;
#(
  parameter int NUM_REQ   = INSTR_ARB_NUM_REQ,
  parameter int REQ_IDX_W = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [REQ_IDX_W-1:0] rr_ptr,
  output logic                 any_req,
  output logic [REQ_IDX_W-1:0] grant
);

  int idx;

  // NOTE: combinational block uses blocking assignments and gives every output a
  // default first, so no latch is inferred on any path.
  always_comb begin
    any_req = |req;
    grant   = '0;
    idx     = 0;
    // Walk offsets from far to near so the nearest request to rr_ptr wins last.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (req[idx]) begin
        grant = REQ_IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/instr_mem_arbiter.sv
// Round-robin arbiter sharing one instruction-memory port among NUM_REQ fetchers.
// Define ARB_ADDR_BROADCAST_EN to serve every requester fetching the granted address.
module instr_mem_arbiter
  import common_pkg::*;
#(
  parameter  int NUM_REQ   = INSTR_ARB_NUM_REQ,
  localparam int REQ_IDX_W = idx_width(NUM_REQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NUM_REQ-1:0] req_valid,
  input  instr_mem_addr_t req_addr [NUM_REQ],
  output logic [NUM_REQ-1:0] req_resp_ready,
  output instr_t          req_resp_data,
  output logic            mem_valid,
  output instr_mem_addr_t mem_addr,
  input  logic            mem_resp_ready,
  input  instr_t          mem_resp_data
);

  localparam logic [1:0] S_IDLE  = 2'(ARB_IDLE);
  localparam logic [1:0] S_ISSUE = 2'(ARB_ISSUE);
  localparam logic [1:0] S_RESP  = 2'(ARB_RESP);

  logic [1:0]           state_q, state_d;
  logic [REQ_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [REQ_IDX_W-1:0] grant_q, grant_d;
  logic                 mem_valid_q, mem_valid_d;
  instr_mem_addr_t      mem_addr_q, mem_addr_d;
  logic [NUM_REQ-1:0]   resp_ready_q, resp_ready_d;
  instr_t               resp_data_q, resp_data_d;

  logic                 any_req;
  logic [REQ_IDX_W-1:0] pick;

  rr_priority_picker #(
    .NUM_REQ   (NUM_REQ),
    .REQ_IDX_W (REQ_IDX_W)
  ) u_picker (
    .req     (req_valid),
    .rr_ptr  (rr_ptr_q),
    .any_req (any_req),
    .grant   (pick)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    mem_valid_d  = mem_valid_q;
    mem_addr_d   = mem_addr_q;
    resp_ready_d = '0;
    resp_data_d  = resp_data_q;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          grant_d     = pick;
          mem_addr_d  = req_addr[pick];
          mem_valid_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_resp_ready) begin
          mem_valid_d = 1'b0;
          resp_data_d = mem_resp_data;
          for (int i = 0; i < NUM_REQ; i++) begin
`ifdef ARB_ADDR_BROADCAST_EN
            resp_ready_d[i] = (grant_q == REQ_IDX_W'(i)) ||
                              (req_valid[i] && (req_addr[i] == mem_addr_q));
`else
            resp_ready_d[i] = (grant_q == REQ_IDX_W'(i));
`endif
          end
          rr_ptr_d = (grant_q == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + REQ_IDX_W'(1);
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        $error("instr_mem_arbiter: illegal state encoding %0d", state_q);
        mem_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments; the data registers are
  // reset too because the reset values of mem_addr and req_resp_data are visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      resp_ready_q <= '0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
      resp_ready_q <= resp_ready_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign mem_valid      = mem_valid_q;
  assign mem_addr       = mem_addr_q;
  assign req_resp_ready = resp_ready_q;
  assign req_resp_data  = resp_data_q;

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Bench for instr_mem_arbiter: vector table of fetch transactions, a response
// scoreboard, and hand-written stall / reset / spurious-strobe / broadcast sequences.
module tb_instr_mem_arbiter;
  import common_pkg::*;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  instr_mem_addr_t req_addr [N];
  logic [N-1:0]    req_resp_ready;
  instr_t          req_resp_data;
  logic            mem_valid;
  instr_mem_addr_t mem_addr;
  logic            mem_resp_ready;
  instr_t          mem_resp_data;

  always #5 clk = ~clk;

  instr_mem_arbiter #(.NUM_REQ(N)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_resp_ready (req_resp_ready),
    .req_resp_data  (req_resp_data),
    .mem_valid      (mem_valid),
    .mem_addr       (mem_addr),
    .mem_resp_ready (mem_resp_ready),
    .mem_resp_data  (mem_resp_data)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [N-1:0] mask;
    instr_t       data;
  } resp_t;

  resp_t sb_q[$];
  resp_t mon_e;
  logic [N-1:0] prev_pulse = '0;
  logic         prev_mv    = 1'b0;
  int           mem_txns   = 0;

  // Response monitor: every pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (prev_pulse != '0) check("pulse_width", 32'(req_resp_ready), 32'h0);
    if (req_resp_ready != '0) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", 32'(req_resp_ready), 32'h0);
      end else begin
        mon_e = sb_q.pop_front();
        check("resp_mask", 32'(req_resp_ready), 32'(mon_e.mask));
        check("resp_data", req_resp_data, mon_e.data);
      end
    end
    if (mem_valid && !prev_mv) mem_txns++;
    prev_pulse = req_resp_ready;
    prev_mv    = mem_valid;
  end

  // One fetch transaction: add requests, wait for issue, stall the memory, strobe,
  // wait for the pulse, then the served fetchers drop req_valid.
  task automatic txn(input string name, input logic [N-1:0] add, input logic [N-1:0] exp_mask,
                     input instr_mem_addr_t exp_addr, input int stall, input instr_t data,
                     output int issue_wait, output int pulse_wait);
    int n;
    resp_t e;
    req_valid = req_valid | add;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_valid && n < 20);
    issue_wait = n;
    check({name, "/issue"}, 32'(mem_valid), 32'h1);
    check({name, "/mem_addr"}, mem_addr, exp_addr);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check({name, "/stall_valid"}, 32'(mem_valid), 32'h1);
      check({name, "/stall_addr"}, mem_addr, exp_addr);
      check({name, "/stall_no_pulse"}, 32'(req_resp_ready), 32'h0);
    end
    mem_resp_ready = 1'b1;
    mem_resp_data  = data;
    e.mask = exp_mask;
    e.data = data;
    sb_q.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      mem_resp_ready = 1'b0;
      n++;
    end while (req_resp_ready == '0 && n < 20);
    pulse_wait = n;
    check({name, "/pulse_seen"}, 32'(req_resp_ready != '0), 32'h1);
    check({name, "/mem_valid_low"}, 32'(mem_valid), 32'h0);
    req_valid = req_valid & ~req_resp_ready;
  endtask

  typedef struct {
    string           name;
    logic [N-1:0]    add;
    logic [N-1:0]    exp_mask;
    instr_mem_addr_t exp_addr;
    int              stall;
    instr_t          data;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int iw, pw, base, wait_n;
    reset = 1'b1;
    req_valid = '0;
    mem_resp_ready = 1'b0;
    mem_resp_data = '0;
    for (int i = 0; i < N; i++) req_addr[i] = 32'(32'h10 * (i + 1));

    vecs[0] = '{"single",     4'b0001, 4'b0001, 32'h10, 0, 32'hDEADBEEF};
    vecs[1] = '{"only3",      4'b1000, 4'b1000, 32'h40, 1, 32'h11110001};
    vecs[2] = '{"rr_all_g0",  4'b1111, 4'b0001, 32'h10, 0, 32'h22220002};
    vecs[3] = '{"rr_all_g1",  4'b0000, 4'b0010, 32'h20, 2, 32'h33330003};
    vecs[4] = '{"rr_all_g2",  4'b0000, 4'b0100, 32'h30, 0, 32'h44440004};
    vecs[5] = '{"rr_all_g3",  4'b0000, 4'b1000, 32'h40, 0, 32'h55550005};
    vecs[6] = '{"set_ptr2",   4'b0010, 4'b0010, 32'h20, 0, 32'h66660006};
    vecs[7] = '{"wrap_g3",    4'b1001, 4'b1000, 32'h40, 0, 32'h77770007};
    vecs[8] = '{"wrap_g0",    4'b0000, 4'b0001, 32'h10, 0, 32'h88880008};
    vecs[9] = '{"stall5",     4'b0100, 4'b0100, 32'h30, 5, 32'h99990009};

    repeat (3) @(negedge clk);
    check("reset/mem_valid", 32'(mem_valid), 32'h0);
    check("reset/mem_addr", mem_addr, 32'h0);
    check("reset/resp_ready", 32'(req_resp_ready), 32'h0);
    check("reset/resp_data", req_resp_data, 32'h0);
    reset = 1'b0;

    for (int v = 0; v < 10; v++) begin
      txn(vecs[v].name, vecs[v].add, vecs[v].exp_mask, vecs[v].exp_addr,
          vecs[v].stall, vecs[v].data, iw, pw);
      if (v == 0) begin
        check("single/issue_latency", 32'(iw), 32'h1);
        check("single/pulse_latency", 32'(pw), 32'h1);
      end
    end
    check("table/mem_txns", 32'(mem_txns), 32'd10);

    // Strobe during RESP and then IDLE with no requests: nothing moves.
    mem_resp_ready = 1'b1;
    mem_resp_data  = 32'hCAFEF00D;
    repeat (3) begin
      @(negedge clk);
      check("spurious/mem_valid", 32'(mem_valid), 32'h0);
      check("spurious/resp_ready", 32'(req_resp_ready), 32'h0);
      check("spurious/resp_data", req_resp_data, 32'h99990009);
    end
    mem_resp_ready = 1'b0;

    // Reset during ISSUE, then a late memory strobe.
    req_valid = 4'b0100;
    wait_n = 0;
    do begin
      @(negedge clk);
      wait_n++;
    end while (!mem_valid && wait_n < 20);
    check("rst_issue/mem_addr", mem_addr, 32'h30);
    reset = 1'b1;
    req_valid = '0;
    @(negedge clk);
    reset = 1'b0;
    mem_resp_ready = 1'b1;
    mem_resp_data  = 32'hBAD0BAD0;
    repeat (2) begin
      @(negedge clk);
      check("rst_issue/mem_valid", 32'(mem_valid), 32'h0);
      check("rst_issue/mem_addr", mem_addr, 32'h0);
      check("rst_issue/resp_ready", 32'(req_resp_ready), 32'h0);
      check("rst_issue/resp_data", req_resp_data, 32'h0);
    end
    mem_resp_ready = 1'b0;
    txn("post_rst_g1", 4'b1010, 4'b0010, 32'h20, 0, 32'hA0A0A0A1, iw, pw);
    txn("post_rst_g3", 4'b0000, 4'b1000, 32'h40, 0, 32'hA0A0A0A3, iw, pw);
    txn("post_rst_g0", 4'b0001, 4'b0001, 32'h10, 0, 32'hA0A0A0A0, iw, pw);

    // Requesters 1 and 3 fetch the same address with rr_ptr at 1.
    req_addr[1] = 32'h40;
    base = mem_txns;
`ifdef ARB_ADDR_BROADCAST_EN
    txn("bcast", 4'b1010, 4'b1010, 32'h40, 1, 32'hB0B0B0B0, iw, pw);
    check("bcast/mem_txns", 32'(mem_txns - base), 32'd1);
    txn("bcast_next_g2", 4'b0101, 4'b0100, 32'h30, 0, 32'hB0B0B0B2, iw, pw);
    txn("bcast_next_g0", 4'b0000, 4'b0001, 32'h10, 0, 32'hB0B0B0B3, iw, pw);
`else
    txn("nobcast_g1", 4'b1010, 4'b0010, 32'h40, 1, 32'hB0B0B0B0, iw, pw);
    txn("nobcast_g3", 4'b0000, 4'b1000, 32'h40, 0, 32'hB0B0B0B1, iw, pw);
    check("nobcast/mem_txns", 32'(mem_txns - base), 32'd2);
    txn("nobcast_next_g0", 4'b0101, 4'b0001, 32'h10, 0, 32'hB0B0B0B2, iw, pw);
    txn("nobcast_next_g2", 4'b0000, 4'b0100, 32'h30, 0, 32'hB0B0B0B3, iw, pw);
`endif

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
